// File: rtl/phase_shift_multi.sv
// Multi-channel divided/phase-shifted clock generator running off one fast timebase.
// Each channel has shadowed divide/phase/high settings that take effect at a period boundary.
module phase_shift_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2,
    parameter int DEF_DIV      = 2,
    parameter int DEF_HIGH     = 1,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                PWRDWN,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_phase,
    input  logic [CNT_W-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] lock,
    output logic                locked_all
);

    // Handshake: a write transfers on a rising clk edge where cfg_valid && cfg_ready.
    // cfg_ready depends only on the addressed channel's pending flag (and PWRDWN).
    logic [CHANNELS-1:0] pend_v;
    logic [CHANNELS-1:0] en;
    logic                ch_ok;

    assign ch_ok      = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    assign cfg_ready  = PWRDWN || !ch_ok || !pend_v[cfg_ch];
    assign locked_all = (|en) && (&(lock | ~en));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] div_act, ph_act, hi_act;
        logic [CNT_W-1:0] div_sh, ph_sh, hi_sh;
        logic [CNT_W-1:0] cnt;
        logic             pend, out_q, lock_q;
        logic [3:0]       periods, periods_nx;
        logic             sel, wrap, apply_now, applying, restart, out_nx, lock_nx;
        logic [CNT_W:0]   div_x, ph_x, cnt_x, hi_x, ph_eff, p;

        always_comb begin
            sel       = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
            wrap      = (div_act != '0) && (cnt == div_act - 1'b1);
            apply_now = PWRDWN || sync || (div_act == '0) || wrap;
            applying  = apply_now && (pend || sel);
            restart   = PWRDWN || sync || applying;

            // Position within the period, relative to the phase-shifted rising edge.
            div_x  = {1'b0, div_act};
            ph_x   = {1'b0, ph_act};
            cnt_x  = {1'b0, cnt};
            hi_x   = {1'b0, hi_act};
            ph_eff = (ph_x >= div_x) ? div_x - 1'b1 : ph_x;
            p      = (cnt_x >= ph_eff) ? cnt_x - ph_eff : cnt_x + div_x - ph_eff;
            out_nx = !PWRDWN && (div_act != '0) && (p < hi_x);

            periods_nx = periods;
            if (restart)
                periods_nx = '0;
            else if (wrap && periods != 4'(LOCK_PERIODS))
                periods_nx = periods + 4'd1;
            lock_nx = (periods_nx == 4'(LOCK_PERIODS)) && (div_act != '0);
        end

        always_ff @(posedge clk or negedge RST) begin
            if (!RST) begin
                div_act <= CNT_W'(DEF_DIV);
                ph_act  <= '0;
                hi_act  <= CNT_W'(DEF_HIGH);
                div_sh  <= '0;
                ph_sh   <= '0;
                hi_sh   <= '0;
                cnt     <= '0;
                pend    <= 1'b0;
                periods <= '0;
                out_q   <= 1'b0;
                lock_q  <= 1'b0;
            end else begin
                if (restart || wrap || div_act == '0)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;

                // A write arriving on an apply cycle bypasses the shadow entirely.
                if (sel && apply_now) begin
                    div_act <= cfg_div;
                    ph_act  <= cfg_phase;
                    hi_act  <= cfg_high;
                    pend    <= 1'b0;
                end else if (sel) begin
                    div_sh  <= cfg_div;
                    ph_sh   <= cfg_phase;
                    hi_sh   <= cfg_high;
                    pend    <= 1'b1;
                end else if (pend && apply_now) begin
                    div_act <= div_sh;
                    ph_act  <= ph_sh;
                    hi_act  <= hi_sh;
                    pend    <= 1'b0;
                end

                periods <= periods_nx;
                out_q   <= out_nx;
                lock_q  <= lock_nx;
            end
        end

        assign clk_out[g] = out_q;
        assign lock[g]    = lock_q;
        assign en[g]      = (div_act != '0);
        assign pend_v[g]  = pend;
    end

endmodule

// File: tb/tb_phase_shift_multi.sv
// Bench for phase_shift_multi: defaults, phase patterns, table of channel-2 settings,
// mid-period reconfiguration, power-down and asynchronous reset.
module tb_phase_shift_multi;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int CH_W     = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                pwrdwn = 1'b0;
    logic                sync = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [CNT_W-1:0]    cfg_div = '0;
    logic [CNT_W-1:0]    cfg_phase = '0;
    logic [CNT_W-1:0]    cfg_high = '0;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] lock;
    logic                locked_all;

    phase_shift_multi #(
        .CHANNELS(CHANNELS), .CNT_W(CNT_W), .LOCK_PERIODS(2), .DEF_DIV(2), .DEF_HIGH(1)
    ) dut (
        .clk(clk), .RST(rst), .PWRDWN(pwrdwn), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_high(cfg_high),
        .clk_out(clk_out), .lock(lock), .locked_all(locked_all)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: entries are {locked_all, lock[3:0], clk_out[3:0]}
    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0]  div;
        logic [7:0]  ph;
        logic [7:0]  high;
        logic [11:0] pat;
        logic        lk;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input logic [8:0] mask);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, {23'd0, {locked_all, lock, clk_out} & mask}, {23'd0, e & mask});
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [CH_W-1:0] ch, input logic [7:0] dv,
                             input logic [7:0] ph, input logic [7:0] hi);
        logic done;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_phase = ph;
        cfg_high  = hi;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            done = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        check("write_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    // Default settings after reset: every channel div=2 high=1, locks after two wraps.
    task automatic default_run(input string name);
        exp_q.push_back(9'b0_0000_1111);
        exp_q.push_back(9'b0_0000_0000);
        exp_q.push_back(9'b0_0000_1111);
        exp_q.push_back(9'b1_1111_0000);
        exp_q.push_back(9'b1_1111_1111);
        exp_q.push_back(9'b1_1111_0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            sb_pop(name, 9'h1FF);
        end
    endtask

    initial begin
        tbl[0] = '{8'd5,   8'd0,   8'd0,   12'h000,          1'b1};
        tbl[1] = '{8'd5,   8'd0,   8'd7,   12'hFFF,          1'b1};
        tbl[2] = '{8'd5,   8'd2,   8'd2,   12'b000110001100, 1'b1};
        tbl[3] = '{8'd3,   8'd7,   8'd1,   12'b100100100100, 1'b1};
        tbl[4] = '{8'd0,   8'd0,   8'd3,   12'h000,          1'b0};
        tbl[5] = '{8'd1,   8'd0,   8'd1,   12'hFFF,          1'b1};
        tbl[6] = '{8'd255, 8'd254, 8'd200, 12'hFFF,          1'b0};
        tbl[7] = '{8'd4,   8'd0,   8'd4,   12'hFFF,          1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out", {28'd0, clk_out}, 32'd0);
        check("rst_lock", {28'd0, lock}, 32'd0);
        check("rst_locked_all", {31'd0, locked_all}, 32'd0);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        #3 rst = 1'b1;
        default_run("default_after_reset");

        // quadrature pair on ch0/ch1, realigned by sync
        write_cfg(2'd0, 8'd4, 8'd0, 8'd2);
        write_cfg(2'd1, 8'd4, 8'd1, 8'd2);
        pulse_sync();
        exp_q.push_back(9'b0_0000_1101);
        exp_q.push_back(9'b0_0000_0011);
        exp_q.push_back(9'b0_0000_1110);
        exp_q.push_back(9'b0_1100_0000);
        exp_q.push_back(9'b0_1100_1101);
        exp_q.push_back(9'b0_1100_0011);
        exp_q.push_back(9'b0_1100_1110);
        exp_q.push_back(9'b1_1111_0000);
        exp_q.push_back(9'b1_1111_1101);
        for (int i = 0; i < 9; i++) begin
            tick();
            sb_pop("quadrature", 9'h1FF);
        end

        // table of ch2 settings, each aligned by sync; lock[2] checked on the last cycle
        for (int t = 0; t < 8; t++) begin
            write_cfg(2'd2, tbl[t].div, tbl[t].ph, tbl[t].high);
            pulse_sync();
            for (int i = 0; i < 12; i++) begin
                logic [8:0] e;
                e    = '0;
                e[2] = tbl[t].pat[i];
                e[6] = tbl[t].lk;
                exp_q.push_back(e);
            end
            for (int i = 0; i < 12; i++) begin
                tick();
                sb_pop($sformatf("tbl%0d_cyc%0d", t, i), (i == 11) ? 9'h044 : 9'h004);
            end
        end

        // disabled ch2 is ignored by locked_all
        write_cfg(2'd2, 8'd0, 8'd0, 8'd0);
        repeat (12) tick();
        check("dis_lock", {28'd0, lock}, 32'hB);
        check("dis_clk2", {31'd0, clk_out[2]}, 32'd0);
        check("dis_locked_all", {31'd0, locked_all}, 32'd1);

        // mid-period reconfiguration of ch0 to div=6
        pulse_sync();
        repeat (9) tick();
        for (int k = 11; k <= 26; k++) begin
            logic [8:0] e;
            e    = '0;
            e[0] = (k <= 13) ? (((k - 2) % 4) < 2) : (((k - 14) % 6) < 3);
            e[4] = (k <= 12) || (k >= 25);
            exp_q.push_back(e);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd6;
        cfg_phase = 8'd0;
        cfg_high  = 8'd3;
        #1;
        check("d_ready_idle", {31'd0, cfg_ready}, 32'd1);
        for (int k = 11; k <= 26; k++) begin
            tick();
            sb_pop($sformatf("reconf_k%0d", k), 9'h011);
            if (k == 11) begin
                check("d_ready_pending", {31'd0, cfg_ready}, 32'd0);
                cfg_ch    = 2'd1;
                cfg_div   = 8'd4;
                cfg_phase = 8'd1;
                cfg_high  = 8'd2;
                #1;
                check("d_ready_other", {31'd0, cfg_ready}, 32'd1);
            end else if (k == 12) begin
                cfg_ch    = 2'd0;
                cfg_div   = 8'd6;
                cfg_phase = 8'd0;
                cfg_high  = 8'd3;
                #1;
                check("d_ready_stall", {31'd0, cfg_ready}, 32'd0);
            end else if (k == 13) begin
                check("d_ready_after_wrap", {31'd0, cfg_ready}, 32'd1);
                cfg_valid = 1'b0;
            end
        end

        // power-down with an immediate write to ch3
        pwrdwn = 1'b1;
        tick();
        check("pd_clk_out", {28'd0, clk_out}, 32'd0);
        check("pd_lock", {28'd0, lock}, 32'd0);
        check("pd_locked_all", {31'd0, locked_all}, 32'd0);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_div   = 8'd3;
        cfg_phase = 8'd0;
        cfg_high  = 8'd1;
        #1;
        check("pd_ready", {31'd0, cfg_ready}, 32'd1);
        tick();
        cfg_valid = 1'b0;
        tick();
        check("pd_hold_clk_out", {28'd0, clk_out}, 32'd0);
        pwrdwn = 1'b0;
        exp_q.push_back(9'b0_0000_1001);
        exp_q.push_back(9'b0_0000_0011);
        exp_q.push_back(9'b0_0000_0011);
        exp_q.push_back(9'b0_0000_1000);
        exp_q.push_back(9'b0_0000_0000);
        exp_q.push_back(9'b0_1000_0010);
        for (int i = 0; i < 6; i++) begin
            tick();
            sb_pop("pd_release", 9'h1FF);
        end

        // asynchronous reset mid-period with a write pending on ch0
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd10;
        cfg_phase = 8'd0;
        cfg_high  = 8'd5;
        #1;
        check("f_ready_idle", {31'd0, cfg_ready}, 32'd1);
        tick();
        cfg_valid = 1'b0;
        #1;
        check("f_pending", {31'd0, cfg_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("f_rst_clk_out", {28'd0, clk_out}, 32'd0);
        check("f_rst_lock", {28'd0, lock}, 32'd0);
        check("f_rst_locked_all", {31'd0, locked_all}, 32'd0);
        check("f_rst_ready", {31'd0, cfg_ready}, 32'd1);
        #2 rst = 1'b1;
        default_run("default_after_async_reset");

        // final report
        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
